// File: rtl/serial_frame_tx_if.sv
// Parallel producer handshake into serial_frame_tx: a word moves on a rising
// edge where valid and ready are both high. The producer holds data_in while valid.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic              ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: 0000 start nibble, payload MSB first, optional even
// parity (macro SERIAL_TX_PARITY_EN), then STOP_BITS high stop bits.
module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    serial_frame_tx_if.slave    bus,
    output logic                sOut,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);

    localparam int MAX_A = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAX_C = (MAX_A > STOP_BITS) ? MAX_A : STOP_BITS;
    localparam int CNT_W = $clog2(MAX_C) + 1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [DATA_W-1:0]  sh, sh_nx;
    logic               sout_nx;
    logic               done_nx;
`ifdef SERIAL_TX_PARITY_EN
    logic               par, par_nx;
`endif

    assign bus.ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // sOut is registered, so each transition also loads the bit for the state being entered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sh_nx    = sh;
        sout_nx  = sOut;
        done_nx  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_nx   = par;
`endif
        case (state)
            IDLE: begin
                sout_nx = 1'b1;
                if (bus.valid) begin
                    state_nx = START;
                    cnt_nx   = '0;
                    sh_nx    = bus.data_in;
                    sout_nx  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    par_nx   = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (cnt == CNT_W'(3)) begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    sout_nx  = sh[DATA_W-1];
                    sh_nx    = sh << 1;
                end else begin
                    cnt_nx   = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    cnt_nx   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    state_nx = PAR;
                    sout_nx  = par;
`else
                    state_nx = STOP;
                    sout_nx  = 1'b1;
`endif
                end else begin
                    cnt_nx   = cnt + CNT_W'(1);
                    sout_nx  = sh[DATA_W-1];
                    sh_nx    = sh << 1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
                state_nx = STOP;
                cnt_nx   = '0;
                sout_nx  = 1'b1;
            end
`endif
            STOP: begin
                if (cnt == CNT_W'(STOP_BITS - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    sout_nx  = 1'b1;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                sout_nx  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            sOut  <= 1'b1;
            done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sh    <= sh_nx;
            sOut  <= sout_nx;
            done  <= done_nx;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_nx;
`endif
        end
    end

endmodule
